// File: rtl/disp_pkg.sv
// disp_pkg: shared constants and helpers for the seven-segment scan driver.
// Imported by disp_mux and disp_mux_timer.
package disp_pkg;

  localparam int         DIGITS     = 4;
  localparam logic [7:0] SSEG_BLANK = 8'hFF;
  localparam logic [3:0] AN_OFF     = 4'b1111;

  function automatic logic [3:0] idx_to_an(input logic [1:0] idx);
    idx_to_an = ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/disp_mux_timer.sv
// disp_mux_timer: slot counter and digit index for the display scan.
// Flags the blank window and the frame capture cycle.
module disp_mux_timer
  import disp_pkg::*;
#(
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic       clk,
  input  logic       reset,
  output logic [1:0] idx,
  output logic       slot_blank,
  output logic       frame_cap
);

  localparam int CW = $clog2(DIGIT_CYCLES);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CW'(DIGIT_CYCLES - 1)) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign slot_blank = (cnt < CW'(BLANK_CYCLES));
  assign frame_cap  = (cnt == '0) && (idx == 2'd0);

endmodule

// File: rtl/disp_mux.sv
// disp_mux: four-digit seven-segment scan with per-frame snapshot and blanking.
// Optional PWM dimming when DISP_MUX_DIM_EN is defined.
module disp_mux
  import disp_pkg::*;
#(
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in0,
  input  logic [7:0] in1,
  input  logic [7:0] in2,
  input  logic [7:0] in3,
`ifdef DISP_MUX_DIM_EN
  input  logic [3:0] brightness,
`endif
  output logic [3:0] an,
  output logic [7:0] sseg,
  output logic       frame_start
);

  logic [1:0] idx;
  logic       slot_blank;
  logic       frame_cap;
  logic       lit;
  logic [7:0] sh [DIGITS];

  disp_mux_timer #(
    .DIGIT_CYCLES(DIGIT_CYCLES),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .idx       (idx),
    .slot_blank(slot_blank),
    .frame_cap (frame_cap)
  );

  // Snapshot once per frame so a frame never mixes old and new patterns
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh[0] <= SSEG_BLANK;
      sh[1] <= SSEG_BLANK;
      sh[2] <= SSEG_BLANK;
      sh[3] <= SSEG_BLANK;
    end else if (frame_cap) begin
      sh[0] <= in0;
      sh[1] <= in1;
      sh[2] <= in2;
      sh[3] <= in3;
    end
  end

`ifdef DISP_MUX_DIM_EN
  logic [3:0] pwm_cnt;
  logic [3:0] bri_sh;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt <= '0;
      bri_sh  <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 4'd1;
      if (frame_cap) bri_sh <= brightness;
    end
  end

  always_comb begin
    lit = 1'b0;
    if (!slot_blank)
      lit = (pwm_cnt < bri_sh) || (bri_sh == 4'hF);
  end
`else
  always_comb begin
    lit = !slot_blank;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an          <= AN_OFF;
      sseg        <= SSEG_BLANK;
      frame_start <= 1'b0;
    end else begin
      an          <= lit ? idx_to_an(idx) : AN_OFF;
      sseg        <= lit ? sh[idx] : SSEG_BLANK;
      frame_start <= frame_cap;
    end
  end

endmodule

// File: tb/tb_disp_mux.sv
// tb_disp_mux: scoreboard bench for disp_mux with 8-cycle slots, 2-cycle blank.
// Expected scan frames are queued by stimulus and popped by a negedge monitor.
module tb_disp_mux;

  localparam int DC = 8;
  localparam int BC = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in0, in1, in2, in3;
  logic [3:0] an;
  logic [7:0] sseg;
  logic       frame_start;
`ifdef DISP_MUX_DIM_EN
  logic [3:0] brightness = 4'hF;
`endif

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] sseg;
    logic       fs;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  disp_mux #(
    .DIGIT_CYCLES(DC),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in0        (in0),
    .in1        (in1),
    .in2        (in2),
    .in3        (in3),
`ifdef DISP_MUX_DIM_EN
    .brightness (brightness),
`endif
    .an         (an),
    .sseg       (sseg),
    .frame_start(frame_start)
  );

  task automatic push_idle();
    q.push_back('{an: 4'b1111, sseg: 8'hFF, fs: 1'b0});
  endtask

  // One frame: 4 slots of 2 blank + 6 lit cycles, frame_start on the first
  task automatic push_frame(input logic [7:0] p0, p1, p2, p3);
    exp_t e;
    for (int k = 0; k < 4 * DC; k++) begin
      e.fs   = (k == 0);
      e.an   = 4'b1111;
      e.sseg = 8'hFF;
      if ((k % DC) >= BC) begin
        case (k / DC)
          0: begin e.an = 4'b1110; e.sseg = p0; end
          1: begin e.an = 4'b1101; e.sseg = p1; end
          2: begin e.an = 4'b1011; e.sseg = p2; end
          default: begin e.an = 4'b0111; e.sseg = p3; end
        endcase
      end
      q.push_back(e);
    end
  endtask

  task automatic chk(input string name, input logic [11:0] got, exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  logic [3:0] last_lit = 4'hF;
  int         blank_run = 0;

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({an, sseg, frame_start} !== e) begin
        errors++;
        $display("FAIL scan @%0t: an=%b sseg=%h fs=%b expected an=%b sseg=%h fs=%b",
                 $time, an, sseg, frame_start, e.an, e.sseg, e.fs);
      end
    end
    if (an != 4'hF) begin
      checks++;
      if ($countones(~an) != 1) begin
        errors++;
        $display("FAIL overlap @%0t: an=%b expected one low bit", $time, an);
      end
      if (last_lit != 4'hF && an != last_lit) begin
        checks++;
        if (blank_run < BC) begin
          errors++;
          $display("FAIL gap @%0t: blank run %0d expected >= %0d", $time, blank_run, BC);
        end
      end
      last_lit  = an;
      blank_run = 0;
    end else begin
      blank_run++;
    end
  end

  initial begin
    in0 = 8'hC0; in1 = 8'hF9; in2 = 8'hA4; in3 = 8'hB0;
    repeat (3) push_idle();
    repeat (4) @(posedge clk);
    #2 reset = 1'b0;

    // Capture cycle still shows reset values, then ten frames
    push_idle();
    push_frame(8'hC0, 8'hF9, 8'hA4, 8'hB0);
    push_frame(8'hC0, 8'hF9, 8'hA4, 8'hB0);
    push_frame(8'hC0, 8'hF9, 8'h92, 8'hB0);
    for (int f = 3; f < 10; f++) push_frame(8'h99, 8'hF9, 8'h92, 8'hB0);

    // Mid-frame change while idx=1 of frame 1
    repeat (42) @(posedge clk);
    #2 in2 = 8'h92;
    // Change inside the capture cycle of frame 3
    repeat (54) @(posedge clk);
    #2 in0 = 8'h99;

    // Digit 2 lit, then pulse reset within the cycle
    repeat (244) @(posedge clk);
    #2;
    chk("pre_reset_an", {8'h0, an}, {8'h0, 4'b1011});
    chk("pre_reset_sseg", {4'h0, sseg}, {4'h0, 8'h92});
    reset = 1'b1;
    #1;
    chk("async_an", {8'h0, an}, {8'h0, 4'b1111});
    chk("async_sseg", {4'h0, sseg}, {4'h0, 8'hFF});
    #1 reset = 1'b0;
    push_idle();
    push_frame(8'h99, 8'hF9, 8'h92, 8'hB0);

    for (int i = 0; i < 200 && q.size() > 0; i++) @(posedge clk);
    checks++;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left expected 0", q.size());
    end

`ifdef DISP_MUX_DIM_EN
    brightness = 4'h0;
    repeat (4 * 4 * DC) @(posedge clk);
    for (int i = 0; i < 4 * DC; i++) begin
      @(negedge clk);
      chk("dim0_an", {8'h0, an}, {8'h0, 4'b1111});
    end
    brightness = 4'h4;
    repeat (2 * 4 * DC) @(posedge clk);
    for (int i = 0; i < 4 * DC; i++) begin
      logic [3:0] p;
      @(negedge clk);
      p = dut.pwm_cnt - 4'd1;
      if (an != 4'hF) chk("dim4_pwm", {11'h0, (p < 4'd4)}, 12'h1);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
